wb_stage: RTL
=============

Name: wb_stage

Overview:
- MEM/WB pipeline register and writeback stage of the 5-stage MIPS core.
- Captures the memory-stage result, aligns and extends load data (big-endian), and selects ALU / load / link data.
- Drives the register-file write port (d, rd, rwe) exactly once per retired instruction and exports a forwarding tap for the hazard unit.
- Register file writes on negedge clock, so all write-port outputs come straight from flops and are stable for the whole cycle.

Parameters:
- LINK_OFFSET, 8, added to mem_pc for JAL/JALR/BGEZAL link value.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-high
- stall  in  1  hold stage contents; no capture
- flush  in  1  invalidate incoming instruction
- mem_valid  in  1  MEM stage holds a real instruction
- mem_reg_write  in  1  instruction writes a GPR
- mem_dest  in  5  destination register number
- mem_wb_sel  in  2  0=ALU, 1=load, 2=link, 3=reserved (treated as ALU)
- mem_load_type  in  3  0=LW, 1=LH, 2=LHU, 3=LB, 4=LBU; other codes are treated as LW
- mem_alu_result  in  32  ALU result / effective address
- mem_load_data  in  32  raw aligned word from data memory
- mem_pc  in  32  PC of the instruction
- d  out  5  regfile write address
- rd  out  32  regfile write data
- rwe  out  1  regfile write enable
- fwd_valid  out  1  stage holds a GPR-writing instruction
- fwd_dest  out  5  its destination
- fwd_data  out  32  its result (equals rd)
- misalign  out  1  held load was misaligned; write suppressed
- retired  out  CNT_W  count of retired instructions

Behaviour:
- Reset (async):
  - All flops clear: d=0, rd=0, rwe=0, fwd_valid=0, fwd_dest=0, fwd_data=0, misalign=0, retired=0.
  - The committed flag is set, so nothing is written after release.
- Capture rule, at posedge clock, in priority order:
  - flush: valid<=0.
  - else stall: hold all state.
  - else: load all fields from mem_*, valid<=mem_valid, committed<=0.
- Latency: one cycle. The instruction captured at posedge N drives rwe during cycle N (after the edge) and is written at the following negedge.
- Data selection, computed at capture:
  - ALU: rd = mem_alu_result.
  - Link: rd = mem_pc + LINK_OFFSET, mod 2^32 (wrap-around permitted).
  - Load: byte offset off = mem_alu_result[1:0]. Big-endian lanes: off 0 = bits 31:24, off 3 = bits 7:0.
    - LB / LBU: sign- or zero-extend the selected byte.
    - LH / LHU: halfword at off 0 = bits 31:16, off 2 = bits 15:0, sign- or zero-extended.
    - LW: whole word.
- Misalignment:
  - LH/LHU with off[0]=1, or LW with off!=0, sets misalign=1.
  - The write is suppressed and the instruction does not retire.
  - misalign has no effect for ALU or link selection.
- Write enable:
  - rwe = valid & mem_reg_write(captured) & (dest!=0) & !misalign & !committed.
  - committed is set on the clock edge after rwe is first high.
  - Result: a stalled instruction held in the stage writes exactly once; rwe is 0 in every subsequent held cycle.
- Writes to $0: rwe stays 0, but the instruction still retires.
- Forwarding tap:
  - fwd_valid = valid & reg_write & dest!=0 & !misalign.
  - fwd_valid is independent of committed, so the tap stays live while stalled.
- Retired counter:
  - Increments by 1 on the edge ending the first cycle of each valid, non-misaligned instruction.
  - The increment happens regardless of reg_write, once per instruction, never during held cycles.
  - Wraps at 2^CNT_W.
- Simultaneous events:
  - flush beats stall.
  - reset beats everything; reset mid-write drops the write (rwe falls asynchronously).
- Reserved codes: mem_wb_sel=3 and undefined load types resolve deterministically as listed above, without X.

Decomposition:
- Shared package mips_pkg:
  - wb_sel encodings WB_ALU, WB_LOAD, WB_LINK.
  - load_type encodings LT_LW, LT_LH, LT_LHU, LT_LB, LT_LBU.
  - REG_ZERO = 5'd0.
- Sub-module load_align (combinational): inputs raw word, offset, load type; outputs extended data and misalign flag. It is reused later by the store-path checker.

Test Plan:
- ALU write: mem_valid=1, reg_write=1, dest=5, wb_sel=ALU, alu=0x0000_1234 -> next cycle d=5, rd=0x1234, rwe=1 for one cycle; retired=1.
- Big-endian loads, load_data=0x80FF_7F01:
  - LB off=0 -> rd=0xFFFF_FF80.
  - LBU off=1 -> 0x0000_00FF.
  - LH off=2 -> 0x0000_7F01.
  - LHU off=0 -> 0x0000_80FF.
- Misaligned LW, addr=0x1002 -> misalign=1, rwe=0, fwd_valid=0, retired unchanged.
- Link with wrap: wb_sel=LINK, pc=0xFFFF_FFFC, dest=31 -> rd=0x0000_0004, d=31, rwe=1.
- Stall hold: capture ALU write to dest 7, then stall=1 for 3 cycles -> rwe high only in the first cycle, fwd_valid high all 4 cycles, retired +1.
- Flush, $0 and reset:
  - flush with stall both asserted -> valid=0, no write.
  - dest=0 write -> rwe=0, retired +1.
  - reset asserted mid-cycle while rwe=1 -> rwe=0 immediately, retired=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS core pipeline: writeback source select,
// load width/extension type and the hard-wired zero register.
package mips_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_LINK = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_e;

  typedef enum logic [2:0] {
    LT_LW  = 3'd0,
    LT_LH  = 3'd1,
    LT_LHU = 3'd2,
    LT_LB  = 3'd3,
    LT_LBU = 3'd4
  } load_type_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_align.sv
// Big-endian load lane selection and sign/zero extension, with a misalignment
// flag for halfword and word accesses. Purely combinational.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] rawWord_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  loadType_i,
  output logic [31:0] data_o,
  output logic        misalign_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Byte lane 0 is the most significant byte of the word.
  always_comb begin
    byteSel = rawWord_i[31:24];
    case (offset_i)
      2'd0:    byteSel = rawWord_i[31:24];
      2'd1:    byteSel = rawWord_i[23:16];
      2'd2:    byteSel = rawWord_i[15:8];
      default: byteSel = rawWord_i[7:0];
    endcase
    halfSel = offset_i[1] ? rawWord_i[15:0] : rawWord_i[31:16];
  end

  // Undefined load types fall into the word path so the result is never X.
  always_comb begin
    data_o     = rawWord_i;
    misalign_o = (offset_i != 2'd0);
    case (loadType_i)
      LT_LH: begin
        data_o     = {{16{halfSel[15]}}, halfSel};
        misalign_o = offset_i[0];
      end
      LT_LHU: begin
        data_o     = {16'h0000, halfSel};
        misalign_o = offset_i[0];
      end
      LT_LB: begin
        data_o     = {{24{byteSel[7]}}, byteSel};
        misalign_o = 1'b0;
      end
      LT_LBU: begin
        data_o     = {24'h000000, byteSel};
        misalign_o = 1'b0;
      end
      default: begin
        data_o     = rawWord_i;
        misalign_o = (offset_i != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback stage: selects ALU/load/link data at
// capture and drives the register-file write port and forwarding tap from flops.
module wb_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] LINK_OFFSET = 32'd8,
  parameter int          CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_dest,
  input  logic [1:0]       mem_wb_sel,
  input  logic [2:0]       mem_load_type,
  input  logic [31:0]      mem_alu_result,
  input  logic [31:0]      mem_load_data,
  input  logic [31:0]      mem_pc,
  output logic [4:0]       d,
  output logic [31:0]      rd,
  output logic             rwe,
  output logic             fwd_valid,
  output logic [4:0]       fwd_dest,
  output logic [31:0]      fwd_data,
  output logic             misalign,
  output logic [CNT_W-1:0] retired
);

  logic [31:0] alignData;
  logic        alignMis;
  logic [31:0] selData;
  logic        selMis;

  logic [4:0]       dest_q,     dest_d;
  logic [31:0]      data_q,     data_d;
  logic             rwe_q,      rwe_d;
  logic             fwdValid_q, fwdValid_d;
  logic             misalign_q, misalign_d;
  logic             pending_q,  pending_d;
  logic [CNT_W-1:0] retired_q,  retired_d;

  load_align u_loadAlign (
    .rawWord_i  (mem_load_data),
    .offset_i   (mem_alu_result[1:0]),
    .loadType_i (mem_load_type),
    .data_o     (alignData),
    .misalign_o (alignMis)
  );

  // Reserved select code resolves to the ALU result.
  always_comb begin
    selData = mem_alu_result;
    selMis  = 1'b0;
    case (wb_sel_e'(mem_wb_sel))
      WB_LOAD: begin
        selData = alignData;
        selMis  = alignMis;
      end
      WB_LINK: selData = mem_pc + LINK_OFFSET;
      default: selData = mem_alu_result;
    endcase
  end

  // rwe_q and pending_q are only ever set on capture, so clearing them on a
  // held cycle is what makes a stalled instruction write and retire once.
  always_comb begin
    dest_d     = dest_q;
    data_d     = data_q;
    rwe_d      = rwe_q;
    fwdValid_d = fwdValid_q;
    misalign_d = misalign_q;
    pending_d  = pending_q;
    retired_d  = retired_q + {{(CNT_W-1){1'b0}}, pending_q};
    if (flush) begin
      rwe_d      = 1'b0;
      fwdValid_d = 1'b0;
      misalign_d = 1'b0;
      pending_d  = 1'b0;
    end else if (stall) begin
      rwe_d      = 1'b0;
      pending_d  = 1'b0;
    end else begin
      dest_d     = mem_dest;
      data_d     = selData;
      misalign_d = mem_valid & selMis;
      fwdValid_d = mem_valid & mem_reg_write & (mem_dest != REG_ZERO) & ~selMis;
      rwe_d      = fwdValid_d;
      pending_d  = mem_valid & ~selMis;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dest_q     <= REG_ZERO;
      data_q     <= 32'h0;
      rwe_q      <= 1'b0;
      fwdValid_q <= 1'b0;
      misalign_q <= 1'b0;
      pending_q  <= 1'b0;
      retired_q  <= '0;
    end else begin
      dest_q     <= dest_d;
      data_q     <= data_d;
      rwe_q      <= rwe_d;
      fwdValid_q <= fwdValid_d;
      misalign_q <= misalign_d;
      pending_q  <= pending_d;
      retired_q  <= retired_d;
    end
  end

  assign d         = dest_q;
  assign rd        = data_q;
  assign rwe       = rwe_q;
  assign fwd_valid = fwdValid_q;
  assign fwd_dest  = dest_q;
  assign fwd_data  = data_q;
  assign misalign  = misalign_q;
  assign retired   = retired_q;

endmodule
